// File: rtl/sudoku_board_ctrl.sv
// Sudoku board owner: puzzle load stream, protected single-cell edits, 243-cycle row/col/box scan.
// Define SUDOKU_AUTO_CHECK_EN to launch a scan automatically one cycle after every OK edit.
module sudoku_board_ctrl #(
  parameter int CHECK_GROUPS = 27,
  parameter int GROUP_LEN    = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_start,
  input  logic         load_valid,
  input  logic [3:0]   load_digit,
  output logic         load_ready,
  output logic         load_done,
  input  logic         wr_valid,
  input  logic [3:0]   wr_row,
  input  logic [3:0]   wr_col,
  input  logic [3:0]   wr_digit,
  output logic         wr_ready,
  output logic         wr_resp_valid,
  output logic [1:0]   wr_resp_code,
  input  logic         check_start,
  output logic         check_done,
  output logic         check_ok,
  output logic         solved,
  output logic         busy,
  output logic [323:0] board,
  output logic [80:0]  board_blank
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CHECK = 2'd2} state_t;

  state_t      state;
  logic [3:0]  cells [81];
  logic [80:0] blank;
  logic [6:0]  load_idx;
  logic [4:0]  grp;
  logic [3:0]  elem;
  logic [8:0]  seen;
  logic        conflict;
  logic        zero_seen;
  logic        auto_pend;

  logic        wr_in_range;
  logic [6:0]  wr_idx;
  logic [3:0]  scan_row, scan_col, box;
  logic [6:0]  scan_idx;
  logic [3:0]  scan_dig;
  logic [8:0]  seen_cur, dig_bit;
  logic        dup, last_cell;

`ifndef SUDOKU_AUTO_CHECK_EN
  assign auto_pend = 1'b0;
`endif

  assign wr_in_range = (wr_row <= 4'd8) && (wr_col <= 4'd8) && (wr_digit <= 4'd9);
  assign wr_idx      = {3'b0, wr_row} * 7'd9 + {3'b0, wr_col};
  assign wr_ready    = rst_n && (state == IDLE) && !load_start && !check_start && !auto_pend;
  assign load_ready  = (state == LOAD);
  assign busy        = (state != IDLE);

  for (genvar i = 0; i < 81; i++) begin : g_pack
    assign board[i*4 +: 4] = cells[i];
  end
  assign board_blank = blank;

  // Map (group, element) to a board cell: rows, then columns, then 3x3 boxes.
  always_comb begin
    scan_row = '0;
    scan_col = '0;
    box      = '0;
    if (grp < 5'd9) begin
      scan_row = grp[3:0];
      scan_col = elem;
    end else if (grp < 5'd18) begin
      scan_row = elem;
      scan_col = 4'(grp - 5'd9);
    end else begin
      box      = 4'(grp - 5'd18);
      scan_row = (box / 4'd3) * 4'd3 + elem / 4'd3;
      scan_col = (box % 4'd3) * 4'd3 + elem % 4'd3;
    end
  end

  assign scan_idx  = {3'b0, scan_row} * 7'd9 + {3'b0, scan_col};
  assign scan_dig  = cells[scan_idx];
  assign seen_cur  = (elem == 4'd0) ? 9'd0 : seen;
  assign dig_bit   = (scan_dig == 4'd0) ? 9'd0 : (9'd1 << (scan_dig - 4'd1));
  assign dup       = |(seen_cur & dig_bit);
  assign last_cell = (grp == 5'(CHECK_GROUPS - 1)) && (elem == 4'(GROUP_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      for (int i = 0; i < 81; i++) cells[i] <= '0;
      blank         <= '1;
      load_idx      <= '0;
      grp           <= '0;
      elem          <= '0;
      seen          <= '0;
      conflict      <= 1'b0;
      zero_seen     <= 1'b0;
      load_done     <= 1'b0;
      wr_resp_valid <= 1'b0;
      wr_resp_code  <= 2'd0;
      check_done    <= 1'b0;
      check_ok      <= 1'b0;
      solved        <= 1'b0;
`ifdef SUDOKU_AUTO_CHECK_EN
      auto_pend     <= 1'b0;
`endif
    end else begin
      load_done     <= 1'b0;
      wr_resp_valid <= 1'b0;
      check_done    <= 1'b0;

      if (wr_valid && wr_ready) begin
        wr_resp_valid <= 1'b1;
        if (!wr_in_range) begin
          wr_resp_code <= 2'd2;
        end else if (!blank[wr_idx]) begin
          wr_resp_code <= 2'd1;
        end else begin
          wr_resp_code  <= 2'd0;
          cells[wr_idx] <= wr_digit;
          check_ok      <= 1'b0;
          solved        <= 1'b0;
`ifdef SUDOKU_AUTO_CHECK_EN
          auto_pend     <= 1'b1;
`endif
        end
      end

      case (state)
        IDLE: begin
          if (auto_pend || (!load_start && check_start)) begin
            state     <= CHECK;
            grp       <= '0;
            elem      <= '0;
            conflict  <= 1'b0;
            zero_seen <= 1'b0;
`ifdef SUDOKU_AUTO_CHECK_EN
            auto_pend <= 1'b0;
`endif
          end else if (load_start) begin
            state    <= LOAD;
            load_idx <= '0;
            check_ok <= 1'b0;
            solved   <= 1'b0;
          end
        end
        LOAD: begin
          if (load_valid) begin
            cells[load_idx] <= (load_digit > 4'd9) ? 4'd0 : load_digit;
            blank[load_idx] <= (load_digit == 4'd0) || (load_digit > 4'd9);
            if (load_idx == 7'd80) begin
              state     <= IDLE;
              load_idx  <= '0;
              load_done <= 1'b1;
            end else begin
              load_idx <= load_idx + 7'd1;
            end
          end
        end
        CHECK: begin
          seen      <= seen_cur | dig_bit;
          conflict  <= conflict | dup;
          zero_seen <= zero_seen | (scan_dig == 4'd0);
          if (last_cell) begin
            state      <= IDLE;
            check_ok   <= !(conflict | dup);
            solved     <= !(conflict | dup) && !(zero_seen || (scan_dig == 4'd0));
            check_done <= 1'b1;
          end else if (elem == 4'(GROUP_LEN - 1)) begin
            elem <= '0;
            grp  <= grp + 5'd1;
          end else begin
            elem <= elem + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sudoku_board_ctrl.sv
// Directed bench for sudoku_board_ctrl with a grid-level reference model checked every cycle.
module tb_sudoku_board_ctrl;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load_start = 1'b0, load_valid = 1'b0;
  logic [3:0]   load_digit = '0;
  logic         load_ready, load_done;
  logic         wr_valid = 1'b0;
  logic [3:0]   wr_row = '0, wr_col = '0, wr_digit = '0;
  logic         wr_ready, wr_resp_valid;
  logic [1:0]   wr_resp_code;
  logic         check_start = 1'b0;
  logic         check_done, check_ok, solved, busy;
  logic [323:0] board;
  logic [80:0]  board_blank;

  always #5 clk = ~clk;

  sudoku_board_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_valid(load_valid), .load_digit(load_digit),
    .load_ready(load_ready), .load_done(load_done),
    .wr_valid(wr_valid), .wr_row(wr_row), .wr_col(wr_col), .wr_digit(wr_digit),
    .wr_ready(wr_ready), .wr_resp_valid(wr_resp_valid), .wr_resp_code(wr_resp_code),
    .check_start(check_start), .check_done(check_done), .check_ok(check_ok),
    .solved(solved), .busy(busy), .board(board), .board_blank(board_blank)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [3:0]  mb [81];
  logic [80:0] mblank;
  logic        m_ok, m_solved;
  logic [9:0]  seen_m;
  logic        conf_m, zero_m;
  int          pz [81];
  bit          cmp_en = 1'b0;
  int          sol88;

  task automatic chk(input string name, input logic [323:0] act, input logic [323:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 324'(act), 324'(exp));
  endtask

  function automatic logic [323:0] exp_board();
    logic [323:0] v;
    for (int i = 0; i < 81; i++) v[i*4 +: 4] = mb[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 81; i++) mb[i] = 4'd0;
    mblank   = '1;
    m_ok     = 1'b0;
    m_solved = 1'b0;
  endtask

  function automatic void note(input logic [3:0] d);
    if (d == 4'd0) zero_m = 1'b1;
    else begin
      if (seen_m[d]) conf_m = 1'b1;
      seen_m[d] = 1'b1;
    end
  endfunction

  // Sudoku rules evaluated directly on the model grid.
  task automatic model_scan();
    conf_m = 1'b0;
    zero_m = 1'b0;
    for (int r = 0; r < 9; r++) begin
      seen_m = '0;
      for (int c = 0; c < 9; c++) note(mb[r*9+c]);
    end
    for (int c = 0; c < 9; c++) begin
      seen_m = '0;
      for (int r = 0; r < 9; r++) note(mb[r*9+c]);
    end
    for (int br = 0; br < 3; br++)
      for (int bc = 0; bc < 3; bc++) begin
        seen_m = '0;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++) note(mb[(br*3+dr)*9 + bc*3 + dc]);
      end
    m_ok     = !conf_m;
    m_solved = !conf_m && !zero_m;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("board", board, exp_board());
      chk("board_blank", 324'(board_blank), 324'(mblank));
      chk1("check_ok", check_ok, m_ok);
      chk1("solved", solved, m_solved);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cells(input int n, input bit prio);
    load_start = 1'b1;
    if (prio) begin
      check_start = 1'b1;
      wr_valid = 1'b1; wr_row = 4'd8; wr_col = 4'd8; wr_digit = 4'd1;
      #1 chk1("prio_wr_ready", wr_ready, 1'b0);
    end
    tick();
    load_start = 1'b0; check_start = 1'b0; wr_valid = 1'b0;
    m_ok = 1'b0; m_solved = 1'b0;
    chk1("load_busy", busy, 1'b1);
    chk1("load_ready", load_ready, 1'b1);
    if (prio) chk1("prio_no_resp", wr_resp_valid, 1'b0);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_digit = 4'(pz[i]);
      tick();
      mb[i]     = (pz[i] > 9) ? 4'd0 : 4'(pz[i]);
      mblank[i] = (pz[i] == 0) || (pz[i] > 9);
      if (i < 80) chk1("load_done_early", load_done, 1'b0);
    end
    load_valid = 1'b0;
    if (n == 81) begin
      chk1("load_done_pulse", load_done, 1'b1);
      chk1("load_idle", busy, 1'b0);
      tick();
      chk1("load_done_width", load_done, 1'b0);
    end
  endtask

  task automatic edit(input int r, input int c, input int d, input logic [1:0] code);
    int n;
    wr_valid = 1'b1; wr_row = 4'(r); wr_col = 4'(c); wr_digit = 4'(d);
    #1 chk1("edit_ready", wr_ready, 1'b1);
    tick();
    wr_valid = 1'b0;
    chk1("resp_valid", wr_resp_valid, 1'b1);
    chk("resp_code", 324'(wr_resp_code), 324'(code));
    if (code == 2'd0) begin
      mb[r*9+c] = 4'(d);
      m_ok = 1'b0; m_solved = 1'b0;
    end
`ifdef SUDOKU_AUTO_CHECK_EN
    if (code == 2'd0) begin
      n = 1;
      while (!check_done && n < 400) begin
        chk1("auto_wr_ready", wr_ready, 1'b0);
        tick();
        n++;
      end
      chk("auto_latency", 324'(n), 324'(245));
      model_scan();
    end
`endif
    tick();
    chk1("resp_width", wr_resp_valid, 1'b0);
    if (code != 2'd0) chk1("reject_no_scan", busy, 1'b0);
  endtask

  task automatic run_scan();
    int n;
    check_start = 1'b1;
    tick();
    check_start = 1'b0;
    n = 1;
    chk1("scan_busy", busy, 1'b1);
    while (!check_done && n < 400) begin
      tick();
      n++;
    end
    chk("scan_latency", 324'(n), 324'(244));
    model_scan();
    tick();
    chk1("scan_done_width", check_done, 1'b0);
    chk1("scan_idle", busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    cmp_en = 1'b1;
    tick(); tick();
    chk("rst_board", board, '0);
    chk("rst_blank", 324'(board_blank), 324'({81{1'b1}}));
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_load_ready", load_ready, 1'b0);
    chk1("rst_wr_ready", wr_ready, 1'b0);
    chk1("rst_check_done", check_done, 1'b0);
    rst_n = 1'b1;
    tick();
    chk1("idle_wr_ready", wr_ready, 1'b1);

    for (int i = 0; i < 81; i++) pz[i] = 0;
    pz[0] = 5;
    load_cells(81, 1'b0);
    chk("b00_loaded", 324'(board[3:0]), 324'(4'd5));
    chk1("blank0", board_blank[0], 1'b0);
    chk("blank_rest", 324'(board_blank[80:1]), 324'({80{1'b1}}));

    edit(0, 0, 7, 2'd1);
    chk("b00_protected", 324'(board[3:0]), 324'(4'd5));
    edit(0, 1, 3, 2'd0);
    chk("b01_written", 324'(board[7:4]), 324'(4'd3));
    edit(9, 0, 1, 2'd2);
    edit(0, 9, 1, 2'd2);
    edit(2, 2, 10, 2'd2);
    edit(8, 8, 9, 2'd0);
    chk("b88_written", 324'(board[323:320]), 324'(4'd9));
    edit(8, 8, 0, 2'd0);

`ifndef SUDOKU_AUTO_CHECK_EN
    wr_valid = 1'b1; wr_row = 4'd1; wr_col = 4'd0; wr_digit = 4'd1;
    tick();
    chk1("b2b_resp1", wr_resp_valid, 1'b1);
    chk("b2b_code1", 324'(wr_resp_code), 324'(2'd0));
    mb[9] = 4'd1;
    wr_col = 4'd1; wr_digit = 4'd2;
    #1 chk1("b2b_ready", wr_ready, 1'b1);
    tick();
    chk1("b2b_resp2", wr_resp_valid, 1'b1);
    chk("b2b_code2", 324'(wr_resp_code), 324'(2'd0));
    mb[10] = 4'd2;
    wr_valid = 1'b0;
    tick();
    chk1("b2b_resp_end", wr_resp_valid, 1'b0);
`endif

    edit(0, 4, 3, 2'd0);
    run_scan();
    chk1("conflict_ok", check_ok, 1'b0);
    chk1("conflict_solved", solved, 1'b0);

    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++) pz[r*9+c] = ((r*3 + r/3 + c) % 9) + 1;
    sol88 = pz[80];
    pz[80] = 15;
    load_cells(81, 1'b1);
    chk("sol88_value", 324'(sol88), 324'(8));
    chk("b88_overrange", 324'(board[323:320]), 324'(4'd0));
    chk1("blank80_overrange", board_blank[80], 1'b1);
    run_scan();
    chk1("partial_ok", check_ok, 1'b1);
    chk1("partial_solved", solved, 1'b0);
    edit(8, 8, sol88, 2'd0);
    run_scan();
    chk1("full_ok", check_ok, 1'b1);
    chk1("full_solved", solved, 1'b1);
    edit(4, 4, 1, 2'd1);
    chk1("protected_keeps_solved", solved, 1'b1);
    edit(8, 8, 0, 2'd0);
    chk1("erase_unsolved", solved, 1'b0);

    for (int i = 0; i < 81; i++) pz[i] = (i % 9) + 1;
    load_cells(40, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midload_board", board, '0);
    chk("midload_blank", 324'(board_blank), 324'({81{1'b1}}));
    chk1("midload_busy", busy, 1'b0);
    chk1("midload_load_ready", load_ready, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk1("no_load_done", load_done, 1'b0);
    end
    chk1("post_reset_idle", busy, 1'b0);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sudoku_board_ctrl.md
Name: sudoku_board_ctrl

Overview:
- Owns the Sudoku board state that the VGA game pixel generator reads; this block is the writer side of the `board` / `board_blank` interface.
- Loads a puzzle as a stream of 81 cells and accepts single-cell edits from the handwriting/recognition path.
- Protects given cells.
- Runs a multi-cycle row/column/box conflict scan that reports valid/solved status to the game FSM.

Parameters:
- `CHECK_GROUPS`, default 27, number of scanned groups (9 rows + 9 cols + 9 boxes); fixed, not for override.
- `GROUP_LEN`, default 9, cells per group; fixed.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `load_start` in 1: pulse; begin puzzle load.
- `load_valid` in 1: load cell valid.
- `load_digit` in 4: cell value, row-major order; 0 = blank/editable, 1-9 = given.
- `load_ready` out 1: load cell accepted when `load_valid & load_ready`.
- `load_done` out 1: one-cycle pulse after the 81st cell.
- `wr_valid` in 1: edit request.
- `wr_row` in 4: row 0-8.
- `wr_col` in 4: column 0-8.
- `wr_digit` in 4: 0 (erase) or 1-9.
- `wr_ready` out 1: edit accepted when `wr_valid & wr_ready`.
- `wr_resp_valid` out 1: one-cycle pulse, one cycle after acceptance.
- `wr_resp_code` out 2: 0 OK, 1 PROTECTED, 2 RANGE; valid with `wr_resp_valid`.
- `check_start` in 1: pulse; begin conflict scan.
- `check_done` out 1: one-cycle pulse at end of scan.
- `check_ok` out 1: last scan found no duplicate nonzero digit in any group.
- `solved` out 1: last scan had `check_ok`=1 and no zero cell.
- `busy` out 1: state != IDLE.
- `board` out 324: cell (r,c) at bits [idx*4+3 : idx*4], where idx = r*9+c.
- `board_blank` out 81: bit idx = 1 means the cell is editable.

Behaviour:
- Reset (async, `rst_n` low):
  - `board` = 0; `board_blank` = all 1s.
  - `state` = IDLE; all counters = 0.
  - `load_ready`, `load_done`, `wr_ready`, `wr_resp_valid`, `wr_resp_code`, `check_done`, `check_ok`, `solved`, `busy` = 0.
  - Reset in any state abandons the operation; no partial response is issued.
- States: IDLE, LOAD, CHECK.
- IDLE priority, same cycle: `load_start` > `check_start` > `wr_valid`.
  - `wr_ready` = (state==IDLE) & !`load_start` & !`check_start`.
- LOAD:
  - `load_ready` = 1. Each accepted cell writes `board[idx]` = `load_digit` and `board_blank[idx]` = (`load_digit`==0), then idx++.
  - Digits > 9 are stored as 0 and marked blank.
  - After idx 80 is accepted: IDLE, and `load_done` pulses the next cycle.
  - Entering LOAD clears `check_ok` and `solved`.
  - `load_start` while in LOAD is ignored.
- Edit, on acceptance in IDLE (registered):
  - `wr_row` > 8, `wr_col` > 8 or `wr_digit` > 9: RANGE; no state change.
  - Else `board_blank[idx]` = 0: PROTECTED; no change.
  - Else `board[idx]` = `wr_digit`: OK; `solved` and `check_ok` are cleared.
  - Response pulse follows the accept cycle by exactly 1 cycle.
  - Back-to-back edits are accepted every cycle.
- CHECK:
  - Group counter g 0-26 and element counter k 0-8, one cell per cycle, 243 cycles total.
  - Cell order:
    - g < 9 (rows): row g, col k.
    - 9 ≤ g < 18 (cols): row k, col g-9.
    - g ≥ 18 (boxes), with b = g-18: row (b/3)*3 + k/3, col (b%3)*3 + k%3.
  - A 9-bit seen mask is cleared at k = 0 of each group.
  - Conflict flag is set if the digit is nonzero and its seen bit is already set.
  - Zero flag is set on any zero cell.
  - After the last cell:
    - `check_ok` = !conflict.
    - `solved` = !conflict & !zero.
    - `check_done` pulses.
    - Return to IDLE.
  - `check_done` is high exactly 244 cycles after the cycle `check_start` was sampled.
  - `check_start` while busy is ignored.
  - `board` is stable during CHECK because no writes are accepted.
- Address arithmetic: idx = row*9+col, 7 bits; no wrap, range is checked before use.

Optional Feature:
- Macro `SUDOKU_AUTO_CHECK_EN`.
- Defined:
  - Every OK edit transitions to CHECK in the cycle after acceptance, in parallel with the response pulse.
  - `wr_ready` stays low until `check_done`.
  - PROTECTED/RANGE edits do not trigger a scan.
- Undefined: scans run only on `check_start`.

Test Plan:
- Reset check: assert `rst_n`=0 mid-LOAD at cell 40 → `board`=0, `board_blank`=all 1s, `busy`=0, `load_done` never pulses.
- Load: stream cells with (0,0)=5 and all others 0 → `board[3:0]`=5, `board_blank[0]`=0, `board_blank[80:1]`=all 1s, `load_done` pulse after cell 80.
- Edits after that load:
  - (0,0)=7 → code 1, `board[3:0]` stays 5.
  - (0,1)=3 → code 0, `board[7:4]`=3.
  - row=9 → code 2.
  - Each response arrives 1 cycle after accept.
- Conflict scan: board with 3 at (0,1) and (0,4), `check_start` → `check_done` 244 cycles later, `check_ok`=0, `solved`=0.
- Solved scan: load a valid complete solution, `check_start` → `check_ok`=1, `solved`=1.
  - Then edit any blank-loaded cell → `solved` drops to 0.
- Priority: assert `load_start`, `check_start` and `wr_valid` in the same cycle in IDLE → LOAD entered, `wr_ready`=0, no `wr_resp_valid`.
- With `SUDOKU_AUTO_CHECK_EN`: an OK edit yields `check_done` 245 cycles after accept, with `wr_ready`=0 throughout.
